wbm32_cmd: RTL and testbench
============================

WBM32_CMD -- requirements
Module: wbm32_cmd

Interface
REQ-001 Parameter TIMEOUT, default 16'd255: BUS-state cycles without ack before abort; legal range 1..65535.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high.
REQ-005 cmd_we  in  1  1=write, 0=read; cmd_sel  in  4  byte lanes; cmd_adr  in  32  address; cmd_dat  in  32  write data.
REQ-006 rsp_valid  out  1  response held; rsp_ready  in  1  response consumed when both high.
REQ-007 rsp_dat  out  32  read data (0 for writes or timeout); rsp_err  out  1  transaction timed out.
REQ-008 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each; wb_sel_o  out  4; wb_adr_o, wb_dat_o  out  32: Wishbone32 classic master outputs.
REQ-009 wb_ack_i  in  1; wb_dat_i  in  32: Wishbone32 slave responses.

Function
REQ-010 FSM states IDLE, BUS, RESP; all outputs SHALL be registered except cmd_ready, which SHALL be decoded as (state==IDLE).
REQ-011 IDLE: on cmd_valid, capture we/sel/adr/dat into wb_*_o, assert wb_cyc_o=wb_stb_o=1 from the next cycle, clear timeout counter, go BUS.
REQ-012 IDLE without cmd_valid: wb_cyc_o=wb_stb_o=0; wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o hold last values.
REQ-013 BUS: wb_cyc_o, wb_stb_o and all address/data/sel/we outputs SHALL be stable until ack or timeout.
REQ-014 BUS with wb_ack_i=1: deassert wb_cyc_o/wb_stb_o on that edge, rsp_dat<=wb_dat_i if read else 0, rsp_err<=0, rsp_valid<=1, go RESP.
REQ-015 BUS without ack: counter increments by 1 per cycle; when counter==TIMEOUT-1 in a cycle with no ack, deassert cyc/stb, rsp_dat<=0, rsp_err<=1, rsp_valid<=1, go RESP.
REQ-016 Ack in the same cycle as timeout terminal count: ack SHALL win (REQ-014 applies, rsp_err=0).
REQ-017 RESP: rsp_valid, rsp_dat, rsp_err held stable until rsp_ready=1; on that edge rsp_valid<=0, go IDLE.
REQ-018 RESP with rsp_ready=1 and cmd_valid=1 in the same cycle: command not accepted that cycle (cmd_ready=0); accepted earliest the following cycle.
REQ-019 wb_ack_i in IDLE or RESP SHALL be ignored (no state, data or error change).
REQ-020 Latency: command accepted edge N -> stb high cycle N+1; slave acking at edge N+k (k>=2) -> rsp_valid high from cycle after edge N+k.
REQ-021 Counter 16 bits, never wraps: saturates implicitly by the REQ-015 exit.
REQ-022 Max one outstanding transaction; no pipelined or burst cycles; wb_cyc_o==wb_stb_o at all times.

Reset
REQ-023 rst_n low SHALL asynchronously force: state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, counter=0.
REQ-024 Reset mid-BUS SHALL drop cyc/stb immediately (not edge-aligned); the in-flight transaction SHALL be discarded with no response.
REQ-025 Deassertion of rst_n SHALL be synchronised externally; first command acceptable on the first edge after release.

Structure
REQ-026 Shared package wbm32_pkg SHALL hold the state enumeration (IDLE/BUS/RESP) and the default TIMEOUT constant.
REQ-027 Single module, no sub-modules; the timeout counter is inline.

Verification
REQ-028 Write adr=0x0, dat=0x00123456, sel=4'b0111 to a one-cycle-registered-ack slave -> stb high exactly 2 cycles, slave sees 0x123456 (regs 0x56/0x34/0x12), rsp_valid with rsp_dat=0, rsp_err=0.
REQ-029 Read adr=0x0 after REQ-028 -> rsp_dat=0x00123456, rsp_err=0; wb_we_o=0 throughout.
REQ-030 No-ack slave, TIMEOUT=4 -> stb high exactly 4 cycles, then rsp_err=1, rsp_dat=0; next command completes normally.
REQ-031 rsp_ready held low 10 cycles -> rsp_valid/rsp_dat stable 10 cycles, cmd_ready=0, stray wb_ack_i pulses ignored.
REQ-032 rst_n pulled low during BUS -> wb_cyc_o/wb_stb_o low before next clock edge, all outputs at reset values, no rsp_valid after release.
REQ-033 Back-to-back: cmd_valid held high with rsp_ready tied 1 over 3 writes -> each accepted one cycle after previous response, no overlap of cyc.

Source files
------------

// File: rtl/wbm32_pkg.sv
// wbm32_pkg: shared FSM state encoding and default timeout for the Wishbone32 command master.
//   ST_IDLE / ST_BUS / ST_RESP : controller states
//   TIMEOUT_DEF                : BUS-state cycles without ack before abort
package wbm32_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUS  = 2'd1;
    localparam state_t ST_RESP = 2'd2;
    localparam logic [15:0] TIMEOUT_DEF = 16'd255;
endpackage

// File: rtl/wbm32_cmd_if.sv
// wbm32_cmd_if: command/response handshake plus Wishbone32 classic bus between controller and its environment.
//   cmd_*  : command channel (valid/ready, we, sel, adr, dat)
//   rsp_*  : response channel (valid/ready, dat, err)
//   wb_*   : Wishbone32 classic master outputs / slave responses
//   master : controller view; slave : environment view
interface wbm32_cmd_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i;
    logic [31:0] wb_dat_i;
    modport master (
        input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready, wb_ack_i, wb_dat_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
    );
    modport slave (
        output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat, rsp_ready, wb_ack_i, wb_dat_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
               wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
    );
endinterface

// File: rtl/wbm32_cmd.sv
// wbm32_cmd: single-outstanding Wishbone32 classic master driven by a valid/ready command channel.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : wbm32_cmd_if.master (command, response and Wishbone signals)
//   TIMEOUT : BUS cycles without ack before the transaction is aborted with rsp_err (1..65535)
module wbm32_cmd import wbm32_pkg::*; #(
    parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    wbm32_cmd_if.master    bus
);
    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_cyc;
    logic        r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;
    logic        w_timeout;
    assign w_timeout = r_cnt == TIMEOUT - 16'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 16'd0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= 4'd0;
            r_adr       <= 32'd0;
            r_dat       <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.cmd_valid) begin
                    r_we    <= bus.cmd_we;
                    r_sel   <= bus.cmd_sel;
                    r_adr   <= bus.cmd_adr;
                    r_dat   <= bus.cmd_dat;
                    r_cyc   <= 1'b1;
                    r_cnt   <= 16'd0;
                    r_state <= ST_BUS;
                end
                // ack is tested first so it wins over a coincident terminal count
                ST_BUS: if (bus.wb_ack_i) begin
                    r_cyc       <= 1'b0;
                    r_rsp_dat   <= r_we ? 32'd0 : bus.wb_dat_i;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end else if (w_timeout) begin
                    r_cyc       <= 1'b0;
                    r_rsp_dat   <= 32'd0;
                    r_rsp_err   <= 1'b1;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
                ST_RESP: if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    // cyc and stb share one register so they can never disagree
    assign bus.cmd_ready = r_state == ST_IDLE;
    assign bus.wb_cyc_o  = r_cyc;
    assign bus.wb_stb_o  = r_cyc;
    assign bus.wb_we_o   = r_we;
    assign bus.wb_sel_o  = r_sel;
    assign bus.wb_adr_o  = r_adr;
    assign bus.wb_dat_o  = r_dat;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_dat   = r_rsp_dat;
    assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_wbm32_cmd.sv
// tb_wbm32_cmd: randomized and directed checks of wbm32_cmd against a word-level memory/timeout model.
module tb_wbm32_cmd;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    wbm32_cmd_if bus();
    wbm32_cmd #(.TIMEOUT(16'(TO))) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int tests = 0;
    int fails = 0;
    logic [31:0] mem_m [16];
    logic [31:0] s_mem [16];
    logic        s_ack;
    logic        stray;
    logic [31:0] s_dat;
    int          s_lat;
    bit          s_noack;
    int          s_wait;
    assign bus.wb_ack_i = s_ack | stray;
    assign bus.wb_dat_i = s_dat;
    always @(posedge clk) begin
        if (!rst_n) begin
            s_ack  <= 1'b0;
            s_wait <= 0;
        end else if (bus.wb_stb_o && !s_ack) begin
            if (!s_noack && s_wait == s_lat) begin
                s_ack  <= 1'b1;
                s_wait <= 0;
                if (bus.wb_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.wb_sel_o[b]) s_mem[bus.wb_adr_o[5:2]][8*b +: 8] <= bus.wb_dat_o[8*b +: 8];
                end else begin
                    s_dat <= s_mem[bus.wb_adr_o[5:2]];
                end
            end else begin
                s_wait <= s_wait + 1;
            end
        end else begin
            s_ack <= 1'b0;
            if (!bus.wb_stb_o) s_wait <= 0;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) chk("cyc_eq_stb", 32'(bus.wb_cyc_o), 32'(bus.wb_stb_o));
    task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat,
                           input int lat, input bit noack, input int hold, input bit strays);
        int n;
        int exp_n;
        logic [31:0] exp_d;
        logic [3:0] idx;
        idx = adr[5:2];
        exp_n = noack ? TO : lat + 2;
        if (!noack && we)
            for (int b = 0; b < 4; b++) if (sel[b]) mem_m[idx][8*b +: 8] = dat[8*b +: 8];
        exp_d = (!noack && !we) ? mem_m[idx] : 32'd0;
        @(negedge clk);
        s_lat = lat;
        s_noack = noack;
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_we = we;
        bus.cmd_sel = sel;
        bus.cmd_adr = adr;
        bus.cmd_dat = dat;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (bus.wb_stb_o === 1'b1 && n < 300) begin
            chk("bus_adr", bus.wb_adr_o, adr);
            chk("bus_dat", bus.wb_dat_o, dat);
            chk("bus_sel", 32'(bus.wb_sel_o), 32'(sel));
            chk("bus_we", 32'(bus.wb_we_o), 32'(we));
            chk("bus_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            n++;
            @(negedge clk);
        end
        chk("stb_cycles", 32'(n), 32'(exp_n));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_dat", bus.rsp_dat, exp_d);
        chk("rsp_err", 32'(bus.rsp_err), 32'(noack));
        for (int i = 0; i < hold; i++) begin
            if (strays) stray = 1'($urandom % 2);
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_dat", bus.rsp_dat, exp_d);
            chk("hold_err", 32'(bus.rsp_err), 32'(noack));
            chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("hold_stb", 32'(bus.wb_stb_o), 32'd0);
        end
        stray = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("rsp_consumed", 32'(bus.rsp_valid), 32'd0);
        chk("back_idle", 32'(bus.cmd_ready), 32'd1);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [31:0] d;
        for (int i = 0; i < 16; i++) begin
            mem_m[i] = 32'd0;
            s_mem[i] = 32'd0;
        end
        s_dat = 32'd0;
        s_lat = 0;
        s_noack = 1'b0;
        stray = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we = 1'b0;
        bus.cmd_sel = 4'd0;
        bus.cmd_adr = 32'd0;
        bus.cmd_dat = 32'd0;
        bus.rsp_ready = 1'b0;
        #12;
        chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("rst_adr", bus.wb_adr_o, 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        // write 0x00123456 with three lanes, then read it back
        run_txn(1'b1, 4'b0111, 32'h0, 32'h00123456, 0, 1'b0, 0, 1'b0);
        chk("slave_b0", 32'(s_mem[0][7:0]), 32'h56);
        chk("slave_b1", 32'(s_mem[0][15:8]), 32'h34);
        chk("slave_b2", 32'(s_mem[0][23:16]), 32'h12);
        chk("slave_b3", 32'(s_mem[0][31:24]), 32'h00);
        run_txn(1'b0, 4'b1111, 32'h0, 32'hdeadbeef, 0, 1'b0, 0, 1'b0);
        // no-ack slave times out, then a normal command completes
        run_txn(1'b1, 4'b1111, 32'h4, 32'hcafef00d, 0, 1'b1, 0, 1'b0);
        run_txn(1'b0, 4'b1111, 32'h4, 32'h0, 1, 1'b0, 0, 1'b0);
        // ack on the terminal-count cycle wins over the timeout
        run_txn(1'b1, 4'b1111, 32'h8, 32'h11223344, TO - 2, 1'b0, 0, 1'b0);
        run_txn(1'b0, 4'b1111, 32'h8, 32'h0, TO - 2, 1'b0, 0, 1'b0);
        // response held for 10 cycles with stray acks
        run_txn(1'b0, 4'b1111, 32'h0, 32'h0, 0, 1'b0, 10, 1'b1);
        run_txn(1'b0, 4'b1111, 32'h0, 32'h0, 0, 1'b1, 10, 1'b1);
        // reset in the middle of a bus cycle
        s_noack = 1'b1;
        @(negedge clk);
        bus.cmd_we = 1'b1;
        bus.cmd_sel = 4'hf;
        bus.cmd_adr = 32'h0000_0010;
        bus.cmd_dat = 32'h5a5a5a5a;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("pre_rst_stb", 32'(bus.wb_stb_o), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("async_rst_stb", 32'(bus.wb_stb_o), 32'd0);
        chk("async_rst_we", 32'(bus.wb_we_o), 32'd0);
        chk("async_rst_sel", 32'(bus.wb_sel_o), 32'd0);
        chk("async_rst_adr", bus.wb_adr_o, 32'd0);
        chk("async_rst_dat", bus.wb_dat_o, 32'd0);
        chk("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("async_rst_rsp_dat", bus.rsp_dat, 32'd0);
        chk("async_rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("async_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("post_rst_stb", 32'(bus.wb_stb_o), 32'd0);
        end
        run_txn(1'b0, 4'b1111, 32'h0, 32'h0, 0, 1'b0, 1, 1'b0);
        // back-to-back writes with cmd_valid and rsp_ready held high
        s_lat = 0;
        s_noack = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("b2b_ready", 32'(bus.cmd_ready), 32'd1);
            d = $urandom;
            bus.cmd_we = 1'b1;
            bus.cmd_sel = 4'hf;
            bus.cmd_adr = 32'(k * 4 + 32);
            bus.cmd_dat = d;
            bus.cmd_valid = 1'b1;
            mem_m[8 + k] = d;
            @(negedge clk);
            chk("b2b_stb1", 32'(bus.wb_stb_o), 32'd1);
            chk("b2b_no_rsp", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
            chk("b2b_stb2", 32'(bus.wb_stb_o), 32'd1);
            @(negedge clk);
            chk("b2b_stb_off", 32'(bus.wb_stb_o), 32'd0);
            chk("b2b_rsp", 32'(bus.rsp_valid), 32'd1);
            chk("b2b_resp_not_ready", 32'(bus.cmd_ready), 32'd0);
            @(negedge clk);
            chk("b2b_rsp_gone", 32'(bus.rsp_valid), 32'd0);
            chk("b2b_idle_stb", 32'(bus.wb_stb_o), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) run_txn(1'b0, 4'hf, 32'(k * 4 + 32), 32'h0, 0, 1'b0, 0, 1'b0);
        // randomized traffic: latency 0..2 acks, or no ack at all
        for (int t = 0; t < 24; t++) begin
            int m;
            m = int'($urandom % 4);
            run_txn(1'($urandom % 2), 4'($urandom % 16), {$urandom % 1024, 4'($urandom % 16), 2'b00},
                    $urandom, m == 3 ? 0 : m, m == 3, int'($urandom % 3), 1'($urandom % 2));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
